// File: rtl/readout_arbiter_if.sv
// Readout bus between the NetworkInterface uplinks, the arbiter and the downstream sink.
// Signal names are seen from the arbiter side; the master modport drives the arbiter.
interface readout_arbiter_if #(
  parameter int NumPort = 4
);
  logic [NumPort-1:0]    Valid_i;
  logic [32*NumPort-1:0] Data_i;
  logic [NumPort-1:0]    Ready_o;
  logic                  Valid_o;
  logic [31:0]           Data_o;
  logic                  Ready_i;

  modport slave  (input  Valid_i, Data_i, Ready_i, output Ready_o, Valid_o, Data_o);
  modport master (output Valid_i, Data_i, Ready_i, input  Ready_o, Valid_o, Data_o);
endinterface

// File: rtl/readout_arbiter.sv
// Merges NumPort NI uplinks onto one registered output stream using round-robin burst
// grants, and runs the token sweep with a return timeout for the NI ring.
module readout_arbiter #(
  parameter int NumPort    = 4,
  parameter int MaxBurst   = 4,
  parameter int TimeoutCyc = 1024
) (
  input  logic             clk,
  input  logic             rst,
  readout_arbiter_if.slave bus,
  input  logic             Start_i,
  output logic             TokenValid_o,
  input  logic             TokenValid_i,
  output logic             Busy_o,
  output logic             Timeout_o
);
  localparam int GrantW = $clog2(NumPort);
  localparam int TimerW = (TimeoutCyc > 1) ? $clog2(TimeoutCyc) : 1;
  localparam logic [GrantW-1:0] LastPort = GrantW'(NumPort - 1);
  localparam logic [3:0]        LastBeat = 4'(MaxBurst - 1);
  localparam logic [TimerW-1:0] LastTick = TimerW'(TimeoutCyc - 1);

  typedef enum logic {IDLE, LOCK} arbState_t;
  typedef enum logic {SIDLE, SWAIT} sweepState_t;

  arbState_t          arbState, arbStateD;
  logic [GrantW-1:0]  grant, grantD;
  logic [GrantW-1:0]  pointer, pointerD;
  logic [3:0]         burstCnt, burstCntD;
  logic               outValid, outValidD;
  logic [31:0]        outData, outDataD;
  logic [NumPort-1:0] readyOut;
  logic               slotFree;
  logic               found;
  int                 idx;

  sweepState_t        sweepState, sweepStateD;
  logic [TimerW-1:0]  timer, timerD;
  logic               tokenPulse, tokenPulseD;
  logic               timeoutFlag, timeoutFlagD;

  always_comb begin
    // NOTE: every signal written here is defaulted first, so no path can infer a latch.
    arbStateD = arbState;
    grantD    = grant;
    pointerD  = pointer;
    burstCntD = burstCnt;
    outValidD = outValid;
    outDataD  = outData;
    readyOut  = '0;
    found     = 1'b0;
    idx       = 0;
    // The output register can take a word when empty or when it drains this cycle.
    slotFree  = !outValid || bus.Ready_i;
    if (outValid && bus.Ready_i) outValidD = 1'b0;

    unique case (arbState)
      IDLE: begin
        for (int i = 1; i <= NumPort; i++) begin
          idx = (int'(pointer) + i) % NumPort;
          if (!found && bus.Valid_i[idx]) begin
            found  = 1'b1;
            grantD = GrantW'(idx);
          end
        end
        if (found) begin
          arbStateD = LOCK;
          burstCntD = '0;
        end
      end
      LOCK: begin
        readyOut[grant] = slotFree;
        if (bus.Valid_i[grant] && slotFree) begin
          outValidD = 1'b1;
          outDataD  = bus.Data_i[32*int'(grant) +: 32];
          burstCntD = burstCnt + 4'd1;
          if (burstCnt == LastBeat) begin
            arbStateD = IDLE;
            pointerD  = grant;
          end
        end else if (!bus.Valid_i[grant]) begin
          arbStateD = IDLE;
          pointerD  = grant;
        end
      end
    endcase
  end

  always_comb begin
    sweepStateD  = sweepState;
    timerD       = timer;
    tokenPulseD  = 1'b0;
    timeoutFlagD = timeoutFlag;
    unique case (sweepState)
      SIDLE: begin
        if (Start_i) begin
          sweepStateD  = SWAIT;
          tokenPulseD  = 1'b1;
          timerD       = '0;
          timeoutFlagD = 1'b0;
        end
      end
      SWAIT: begin
        timerD = timer + TimerW'(1);
        // A token arriving on the last allowed cycle still counts as a normal return.
        if (TokenValid_i) begin
          sweepStateD = SIDLE;
        end else if (timer == LastTick) begin
          sweepStateD  = SIDLE;
          timeoutFlagD = 1'b1;
        end
      end
    endcase
  end

  // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arbState    <= IDLE;
      grant       <= '0;
      pointer     <= LastPort;
      burstCnt    <= '0;
      outValid    <= 1'b0;
      outData     <= '0;
      sweepState  <= SIDLE;
      timer       <= '0;
      tokenPulse  <= 1'b0;
      timeoutFlag <= 1'b0;
    end else begin
      arbState    <= arbStateD;
      grant       <= grantD;
      pointer     <= pointerD;
      burstCnt    <= burstCntD;
      outValid    <= outValidD;
      outData     <= outDataD;
      sweepState  <= sweepStateD;
      timer       <= timerD;
      tokenPulse  <= tokenPulseD;
      timeoutFlag <= timeoutFlagD;
    end
  end

  assign bus.Ready_o  = readyOut;
  assign bus.Valid_o  = outValid;
  assign bus.Data_o   = outData;
  assign TokenValid_o = tokenPulse;
  assign Busy_o       = (sweepState == SWAIT);
  assign Timeout_o    = timeoutFlag;
endmodule

// File: tb/tb_readout_arbiter.sv
// Bench for readout_arbiter: a per-cycle vector table, hand sequences for stalls, resets
// and token sweeps, and random traffic against a per-port ordering scoreboard.
module tb_readout_arbiter;
  localparam int NP     = 4;
  localparam int MB     = 4;
  localparam int NumVec = 26;

  typedef struct {
    logic [NP-1:0] ready;
    logic          valid;
    logic [31:0]   data;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  readout_arbiter_if #(.NumPort(NP)) bus ();
  readout_arbiter_if #(.NumPort(NP)) busT ();

  logic start = 1'b0, tokIn = 1'b0, tokOut, busy, tmo;
  logic startT = 1'b0, tokInT = 1'b0, tokOutT, busyT, tmoT;

  readout_arbiter #(.NumPort(NP), .MaxBurst(MB), .TimeoutCyc(64)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .Start_i(start), .TokenValid_o(tokOut), .TokenValid_i(tokIn),
    .Busy_o(busy), .Timeout_o(tmo)
  );

  readout_arbiter #(.NumPort(NP), .MaxBurst(MB), .TimeoutCyc(16)) dutT (
    .clk(clk), .rst(rst), .bus(busT.slave),
    .Start_i(startT), .TokenValid_o(tokOutT), .TokenValid_i(tokInT),
    .Busy_o(busyT), .Timeout_o(tmoT)
  );

  int total = 0;
  int bad   = 0;

  logic [NP-1:0] vld = '0;
  logic          rdy = 1'b1;
  logic [23:0]   seq [NP];
  logic [31:0]   sb [$];
  int            accCnt = 0;
  int            outCnt = 0;

  logic [NP-1:0] sReady;
  logic          sValid;
  logic [31:0]   sData;
  logic          sTok, sBusy, sTmo, sTokT, sBusyT, sTmoT;
  logic          protoOn = 1'b0;
  logic          prevStall = 1'b0;
  logic [31:0]   prevData = '0;

  vec_t vec [NumVec];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < NP; k++) bus.Data_i[32*k +: 32] = {8'(k), seq[k]};
    bus.Valid_i = vld;
    bus.Ready_i = rdy;
  endtask

  // One clock cycle: sample at the falling edge, account for handshakes after the rising edge.
  task automatic tick();
    logic [NP-1:0] acc;
    logic          fire;
    @(negedge clk);
    sReady = bus.Ready_o;  sValid = bus.Valid_o;  sData = bus.Data_o;
    sTok   = tokOut;       sBusy  = busy;         sTmo  = tmo;
    sTokT  = tokOutT;      sBusyT = busyT;        sTmoT = tmoT;
    acc  = bus.Valid_i & bus.Ready_o;
    fire = bus.Valid_o & bus.Ready_i;
    if (protoOn) begin
      check("ready_onehot", 64'($onehot0(sReady)), 64'd1);
      if (prevStall) check("hold_stalled", {sValid, sData}, {1'b1, prevData});
    end
    prevStall = protoOn && sValid && !bus.Ready_i;
    prevData  = sData;
    @(posedge clk);
    #1;
    for (int k = 0; k < NP; k++) begin
      if (acc[k]) begin
        sb.push_back({8'(k), seq[k]});
        seq[k] = seq[k] + 24'd1;
        accCnt++;
      end
    end
    if (fire) begin
      int pos = -1;
      for (int i = 0; i < sb.size(); i++)
        if (pos < 0 && sb[i][31:24] == sData[31:24]) pos = i;
      check("sb_word", sData, (pos >= 0) ? sb[pos] : ~sData);
      if (pos >= 0) sb.delete(pos);
      outCnt++;
    end
    drive();
  endtask

  task automatic applyReset();
    rst = 1'b1;
    protoOn = 1'b0;
    prevStall = 1'b0;
    sb.delete();
    accCnt = 0;
    outCnt = 0;
    start = 1'b0; startT = 1'b0; tokIn = 1'b0; tokInT = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    protoOn = 1'b1;
    drive();
  endtask

  task automatic waitGrant(input string name, input logic [NP-1:0] exp);
    int n = 0;
    do begin
      tick();
      n++;
    end while (sReady == '0 && n < 8);
    check(name, sReady, exp);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  initial begin
    int tokCnt, tokCntT, busyCnt, busyCntT, firstTok, firstTmoT;
    logic [31:0] stallData;

    busT.Valid_i = '0;
    busT.Data_i  = '0;
    busT.Ready_i = 1'b1;
    for (int k = 0; k < NP; k++) seq[k] = '0;

    // Expected per-cycle view with every port always valid and the sink always ready:
    // bursts of MB words, one idle cycle between grants, words leave one cycle later.
    for (int t = 0; t < NumVec; t++) begin
      vec[t].ready = '0;
      vec[t].valid = 1'b0;
      vec[t].data  = '0;
      if (t >= 1 && (t - 1) % (MB + 1) < MB)
        vec[t].ready = NP'(1) << (((t - 1) / (MB + 1)) % NP);
      if (t >= 2 && (t - 2) % (MB + 1) < MB) begin
        vec[t].valid = 1'b1;
        vec[t].data  = {8'(((t - 2) / (MB + 1)) % NP),
                        24'((((t - 2) / (MB + 1)) / NP) * MB + (t - 2) % (MB + 1))};
      end
    end

    // Reset state
    vld = '1;
    rdy = 1'b1;
    drive();
    @(negedge clk);
    check("reset_outputs", {bus.Ready_o, bus.Valid_o, bus.Data_o, tokOut, busy, tmo}, 64'd0);
    applyReset();

    // Round-robin bursts from all ports, with sweeps started in the background
    for (int t = 0; t < NumVec; t++) begin
      startT = (t == 0);
      start  = (t == 20);
      tick();
      check($sformatf("vec%0d", t), {sReady, sValid, (sValid ? sData : 32'h0)},
            {vec[t].ready, vec[t].valid, vec[t].data});
    end
    start = 1'b0;
    startT = 1'b0;
    tick();
    tick();

    // Asynchronous reset while locked on port 1 with a word in the output register
    check("pre_reset_locked", {bus.Valid_o, busy, tmoT}, 3'b111);
    #2 rst = 1'b1;
    protoOn = 1'b0;
    prevStall = 1'b0;
    #1;
    check("async_reset_outputs",
          {bus.Ready_o, bus.Valid_o, bus.Data_o, tokOut, busy, tmo, tokOutT, busyT, tmoT}, 64'd0);
    applyReset();
    tick();
    check("no_valid_after_reset", {sValid, sReady}, 0);
    waitGrant("first_grant_after_reset", 4'b0001);

    // Only port 2 offers two words, then drops valid
    vld = 4'b0100;
    applyReset();
    begin
      int n = 0;
      while (accCnt < 2 && n < 20) begin
        tick();
        n++;
      end
    end
    vld = '0;
    drive();
    repeat (5) tick();
    check("p2_words_out", outCnt, 2);
    check("p2_words_in", accCnt, 2);
    check("p2_back_idle", sReady, 0);
    vld = '1;
    drive();
    waitGrant("grant_after_pointer2", 4'b1000);

    // Downstream stall of 5 cycles in the middle of a port 1 burst
    vld = 4'b0010;
    rdy = 1'b1;
    applyReset();
    repeat (3) tick();
    rdy = 1'b0;
    drive();
    tick();
    stallData = sData;
    check("stall_first", {sReady, sValid}, {4'b0000, 1'b1});
    for (int k = 1; k < 5; k++) begin
      tick();
      check($sformatf("stall%0d", k), {sReady, sValid, sData}, {4'b0000, 1'b1, stallData});
    end
    rdy = 1'b1;
    drive();
    repeat (6) tick();
    vld = '0;
    drive();
    repeat (6) tick();
    check("stall_no_loss", {32'(outCnt), 32'(sb.size())}, {32'(accCnt), 32'd0});

    // Token sweeps: return after 30 cycles on dut, no return on dutT (timeout 16)
    applyReset();
    start = 1'b1;
    startT = 1'b1;
    tick();
    start = 1'b0;
    startT = 1'b0;
    tokCnt = 0; tokCntT = 0; busyCnt = 0; busyCntT = 0; firstTok = -1; firstTmoT = -1;
    for (int k = 1; k <= 40; k++) begin
      tokIn = (k == 30 || k == 35);
      start = (k == 10);
      tick();
      if (sTok) begin
        tokCnt++;
        if (firstTok < 0) firstTok = k;
      end
      if (sTokT) tokCntT++;
      if (sBusy) busyCnt++;
      if (sBusyT) busyCntT++;
      if (sTmoT && firstTmoT < 0) firstTmoT = k;
    end
    start = 1'b0;
    tokIn = 1'b0;
    check("token_pulse_count", tokCnt, 1);
    check("token_pulse_cycle", firstTok, 1);
    check("busy_cycles_return", busyCnt, 30);
    check("no_timeout_on_return", sTmo, 0);
    check("tokenT_pulse_count", tokCntT, 1);
    check("busy_cycles_timeout", busyCntT, 16);
    check("timeout_cycle", firstTmoT, 17);
    check("timeout_sticky", sTmoT, 1);

    // Next accepted start clears the flag; a token on the last cycle is a normal return
    startT = 1'b1;
    tick();
    startT = 1'b0;
    busyCntT = 0;
    for (int k = 1; k <= 20; k++) begin
      tokInT = (k == 16);
      tick();
      if (k == 1) check("timeout_cleared", {sTmoT, sBusyT}, 2'b01);
      if (sBusyT) busyCntT++;
    end
    tokInT = 1'b0;
    check("busy_cycles_edge_return", busyCntT, 16);
    check("edge_return_no_timeout", sTmoT, 0);

    // Random traffic against the ordering scoreboard
    vld = '0;
    rdy = 1'b1;
    applyReset();
    for (int c = 0; c < 600; c++) begin
      vld = NP'($urandom);
      rdy = ($urandom_range(0, 3) != 0);
      drive();
      tick();
    end
    vld = '0;
    rdy = 1'b1;
    drive();
    repeat (10) tick();
    check("rand_drained", {32'(outCnt), 32'(sb.size())}, {32'(accCnt), 32'd0});
    check("rand_progress", 64'(accCnt > 50), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/readout_arbiter.md
READOUT_ARBITER -- requirements
Module: readout_arbiter

Interface
REQ-001 SHALL have parameter NumPort, default 4, meaning number of NetworkInterface uplinks merged (2..8).
REQ-002 SHALL have parameter MaxBurst, default 4, meaning max words accepted from one port per grant (1..15).
REQ-003 SHALL have parameter TimeoutCyc, default 1024, meaning cycles allowed for token return before abort.
REQ-004 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port Valid_i  input  NumPort  per-port word valid from NI Valid_o.
REQ-007 SHALL have port Data_i  input  32*NumPort  per-port word; port k at bits [32k+31:32k].
REQ-008 SHALL have port Ready_o  output  NumPort  per-port accept, to NI Ready_i.
REQ-009 SHALL have port Valid_o  output  1  merged word valid.
REQ-010 SHALL have port Data_o  output  32  merged word.
REQ-011 SHALL have port Ready_i  input  1  downstream accept.
REQ-012 SHALL have port Start_i  input  1  one-cycle request to launch a token sweep.
REQ-013 SHALL have port TokenValid_o  output  1  token injected into first NI of ring.
REQ-014 SHALL have port TokenValid_i  input  1  token returned from last NI of ring.
REQ-015 SHALL have port Busy_o  output  1  sweep in progress.
REQ-016 SHALL have port Timeout_o  output  1  sticky flag: token not returned within TimeoutCyc.

Function
REQ-017 SHALL implement arbiter FSM IDLE/LOCK; state, Grant index, Pointer, BurstCnt all registered.
REQ-018 SHALL, in IDLE with any Valid_i high, register Grant = first port with Valid_i high searching Pointer+1, Pointer+2, ... modulo NumPort; go LOCK, BurstCnt=0.
REQ-019 SHALL assert Ready_o only in LOCK, only bit Grant, when output register empty or (Valid_o && Ready_i).
REQ-020 SHALL count a transfer when Valid_i[Grant] && Ready_o[Grant]; word captured into Data_o, Valid_o=1 next cycle (1-cycle latency).
REQ-021 SHALL return LOCK->IDLE, Pointer=Grant, when transfer occurs with BurstCnt==MaxBurst-1, or when Valid_i[Grant]==0 in LOCK.
REQ-022 SHALL hold Valid_o/Data_o stable while Valid_o && !Ready_i; clear Valid_o on Ready_i unless new transfer same cycle.
REQ-023 SHALL sustain 1 word/cycle within a burst when Ready_i held high; one IDLE cycle between grants.
REQ-024 SHALL never drop or duplicate a word; output order per port equals input order.
REQ-025 SHALL implement sweep FSM SIDLE/SWAIT: Start_i in SIDLE -> TokenValid_o pulse exactly 1 cycle next cycle, Busy_o=1, timer=0, SWAIT.
REQ-026 SHALL, in SWAIT, exit to SIDLE with Busy_o=0 on TokenValid_i, or on timer==TimeoutCyc-1 setting Timeout_o=1.
REQ-027 SHALL ignore Start_i while Busy_o=1; ignore TokenValid_i in SIDLE.
REQ-028 SHALL clear Timeout_o only on reset or on next accepted Start_i.
REQ-029 SHALL treat TokenValid_i and timeout expiring same cycle as normal return (Timeout_o unchanged).

Reset
REQ-030 SHALL on rst force: IDLE, SIDLE, Grant=0, Pointer=NumPort-1, BurstCnt=0, timer=0.
REQ-031 SHALL on rst drive Ready_o=0, Valid_o=0, Data_o=0, TokenValid_o=0, Busy_o=0, Timeout_o=0.
REQ-032 SHALL on rst mid-burst discard captured word; no Valid_o after rst deassert until new transfer.

Verification
REQ-033 SHALL cover: after reset all 4 ports Valid_i=1 continuously, Ready_i=1 -> bursts of 4 words from ports 0,1,2,3,0 with 1 idle cycle between.
REQ-034 SHALL cover: only port 2 valid with 2 words then drop -> 2 words on Data_o, FSM back to IDLE, Pointer=2.
REQ-035 SHALL cover: Ready_i=0 for 5 cycles mid-burst -> Data_o stable, Ready_o[Grant]=0, no loss, resumes in order.
REQ-036 SHALL cover: Start_i pulse, TokenValid_i 30 cycles later -> TokenValid_o one pulse, Busy_o high 30 cycles, Timeout_o=0.
REQ-037 SHALL cover: Start_i with no token return, TimeoutCyc=16 -> Busy_o falls after 16 cycles, Timeout_o=1; next Start_i clears it.
REQ-038 SHALL cover: rst asserted during LOCK with Valid_o=1 -> all outputs 0 asynchronously, first grant after release goes to port 0.
